// File: rtl/spike_shift_pkg.sv
// Shared helpers for the spike time-shift pipeline: shift width derivation,
// signed shift clamping and slot-index wrapping.
package spike_shift_pkg;

  localparam int DEF_LEN = 8;

  typedef logic [0:DEF_LEN-1] spike_vec_t;

  function automatic int calc_shw(input int max_mag);
    return $clog2(max_mag + 1) + 1;
  endfunction

  function automatic int clamp_shift(input int s, input int max_mag);
    if (s > max_mag) begin
      return max_mag;
    end
    if (s < -max_mag) begin
      return -max_mag;
    end
    return s;
  endfunction

  // Floor-modulo so that negative source slots rotate to the top of the vector.
  function automatic int wrap_index(input int idx, input int len);
    int m;
    m = idx % len;
    if (m < 0) begin
      m = m + len;
    end
    return m;
  endfunction

endpackage

// File: rtl/spike_shift_core.sv
// Combinational single-channel shifter: Op[b] = Ip[b + s], either rotating
// modulo LEN or zero-filling, and flags spikes pushed out of range.
module spike_shift_core
  import spike_shift_pkg::*;
#(
  parameter int LEN = 8,
  parameter int SHW = 3
) (
  input  logic [0:LEN-1]        i_vec,
  input  logic signed [SHW-1:0] i_shift,
  input  logic                  i_wrap,
  output logic [0:LEN-1]        o_vec,
  output logic                  o_lost
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

  logic [0:LEN-1] w_vec;

  always_comb begin
    w_vec = '0;
    for (int b = 0; b < LEN; b++) begin
      int src;
      src = b + int'(i_shift);
      if (i_wrap) begin
        w_vec[b] = i_vec[IDX_W'(wrap_index(src, LEN))];
      end else if (src >= 0 && src < LEN) begin
        w_vec[b] = i_vec[IDX_W'(src)];
      end
    end
  end

  assign o_vec  = w_vec;
  // A rotation never loses spikes; zero-fill loses exactly when the count drops.
  assign o_lost = !i_wrap && ($countones(w_vec) < $countones(i_vec));

endmodule

// File: rtl/spike_shift_pipe.sv
// Two-stage, NCH-channel spike time shifter with per-channel clamp, OR-merge
// of all channels, and a saturating count of beats that lost spikes.
module spike_shift_pipe
  import spike_shift_pkg::*;
#(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2,
  parameter int NCH           = 4,
  parameter int CNT_W         = 16,
  localparam int SHW          = calc_shw(MAX_SHIFT_MAG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:NCH*LEN-1]   Ip,
  input  logic [NCH*SHW-1:0]   shift,
  input  logic                 wrap_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:NCH*LEN-1]   Op,
  output logic [0:LEN-1]       merged,
  output logic [NCH-1:0]       lost,
  output logic [NCH-1:0]       sat,
  output logic [CNT_W-1:0]     lost_cnt
);

  // Handshake: a beat moves on an edge where valid & ready are both high.
  // Both stages advance together on w_en; ready upstream is w_en itself.
  logic w_en;

  logic                 r_s1_valid;
  logic [0:NCH*LEN-1]   r_s1_vec;
  logic [NCH*SHW-1:0]   r_s1_shift;
  logic [NCH-1:0]       r_s1_sat;
  logic                 r_s1_wrap;

  logic                 r_out_valid;
  logic [0:NCH*LEN-1]   r_op;
  logic [0:LEN-1]       r_merged;
  logic [NCH-1:0]       r_lost;
  logic [NCH-1:0]       r_sat;
  logic [CNT_W-1:0]     r_lost_cnt;

  logic [NCH*SHW-1:0]   w_clamped;
  logic [NCH-1:0]       w_sat;
  logic [0:NCH*LEN-1]   w_op;
  logic [NCH-1:0]       w_lost;
  logic [0:LEN-1]       w_merged;
  logic                 w_xfer;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;
  assign w_xfer   = r_out_valid && out_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [SHW-1:0] w_raw;

    assign w_raw = shift[c*SHW +: SHW];
    assign w_clamped[c*SHW +: SHW] = SHW'(clamp_shift(int'(w_raw), MAX_SHIFT_MAG));
    assign w_sat[c] = (int'(w_raw) > MAX_SHIFT_MAG) || (int'(w_raw) < -MAX_SHIFT_MAG);

    spike_shift_core #(
      .LEN (LEN),
      .SHW (SHW)
    ) u_core (
      .i_vec   (r_s1_vec[c*LEN +: LEN]),
      .i_shift (r_s1_shift[c*SHW +: SHW]),
      .i_wrap  (r_s1_wrap),
      .o_vec   (w_op[c*LEN +: LEN]),
      .o_lost  (w_lost[c])
    );
  end

  always_comb begin
    w_merged = '0;
    for (int c = 0; c < NCH; c++) begin
      w_merged = w_merged | w_op[c*LEN +: LEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_vec    <= '0;
      r_s1_shift  <= '0;
      r_s1_sat    <= '0;
      r_s1_wrap   <= 1'b0;
      r_out_valid <= 1'b0;
      r_op        <= '0;
      r_merged    <= '0;
      r_lost      <= '0;
      r_sat       <= '0;
    end else if (w_en) begin
      r_s1_valid  <= in_valid;
      r_s1_vec    <= Ip;
      r_s1_shift  <= w_clamped;
      r_s1_sat    <= w_sat;
      r_s1_wrap   <= wrap_en;
      r_out_valid <= r_s1_valid;
      r_op        <= w_op;
      r_merged    <= w_merged;
      r_lost      <= w_lost;
      r_sat       <= r_s1_sat;
    end
  end

  // Counts transfers, not stalled cycles, so a held beat is counted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lost_cnt <= '0;
    end else if (w_xfer && (|r_lost) && (r_lost_cnt != {CNT_W{1'b1}})) begin
      r_lost_cnt <= r_lost_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign Op        = r_op;
  assign merged    = r_merged;
  assign lost      = r_lost;
  assign sat       = r_sat;
  assign lost_cnt  = r_lost_cnt;

endmodule

// File: tb/tb_spike_shift_pipe.sv
// Bench for spike_shift_pipe (LEN=8, MAX=2, NCH=2): vector table, hand-built
// latency/backpressure/reset sequences and random traffic with a scoreboard.
module tb_spike_shift_pipe;

  localparam int LEN   = 8;
  localparam int NCH   = 2;
  localparam int SHW   = 3;
  localparam int CNT_W = 16;
  localparam int EW    = NCH*LEN + LEN + NCH + NCH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [0:NCH*LEN-1]   Ip;
  logic [NCH*SHW-1:0]   shift;
  logic                 wrap_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:NCH*LEN-1]   Op;
  logic [0:LEN-1]       merged;
  logic [NCH-1:0]       lost;
  logic [NCH-1:0]       sat;
  logic [CNT_W-1:0]     lost_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  spike_shift_pipe #(
    .LEN           (LEN),
    .MAX_SHIFT_MAG (2),
    .NCH           (NCH),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ip        (Ip),
    .shift     (shift),
    .wrap_en   (wrap_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Op        (Op),
    .merged    (merged),
    .lost      (lost),
    .sat       (sat),
    .lost_cnt  (lost_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference in the time-slot domain: Op[t] = Ip[t - s], slot t at index LEN-1-t.
  function automatic logic [EW-1:0] model_beat(input logic [0:NCH*LEN-1] ip,
                                                 input logic [NCH*SHW-1:0] sh,
                                                 input logic wrap);
    logic [0:NCH*LEN-1] op;
    logic [0:LEN-1]     mg;
    logic [NCH-1:0]     ls;
    logic [NCH-1:0]     st;
    op = '0; mg = '0; ls = '0; st = '0;
    for (int c = 0; c < NCH; c++) begin
      logic [0:LEN-1] iv;
      logic [0:LEN-1] ov;
      int s;
      int sc;
      iv = ip[c*LEN +: LEN];
      s  = int'($signed(sh[c*SHW +: SHW]));
      sc = s;
      if (s > 2) sc = 2;
      if (s < -2) sc = -2;
      st[c] = (sc != s);
      ov = '0;
      for (int t = 0; t < LEN; t++) begin
        int src;
        src = t - sc;
        if (wrap) src = (src + LEN) % LEN;
        if (src >= 0 && src < LEN) ov[3'(LEN-1-t)] = iv[3'(LEN-1-src)];
      end
      ls[c] = !wrap && ($countones(ov) < $countones(iv));
      op[c*LEN +: LEN] = ov;
      mg = mg | ov;
    end
    return {op, mg, ls, st};
  endfunction

  // Called at a negedge; returns at the next negedge.
  task automatic drive_cycle(input logic v, input logic [0:NCH*LEN-1] ip,
                             input logic [NCH*SHW-1:0] sh, input logic wrap,
                             input logic ordy, input logic [EW-1:0] e,
                             output logic acc);
    in_valid  = v;
    Ip        = ip;
    shift     = sh;
    wrap_en   = wrap;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic send(input logic [0:NCH*LEN-1] ip, input logic [NCH*SHW-1:0] sh,
                      input logic wrap, input logic [EW-1:0] e);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) drive_cycle(1'b1, ip, sh, wrap, 1'b1, e, acc);
    if (!acc) check("send_timeout", 32'(acc), 32'(1));
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, '0, 1'b0, ordy, '0, acc);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      idle(1, 1'b1);
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  // Scoreboard: samples just after the driver updates, before the next edge.
  always begin
    @(negedge clk);
    #2;
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got Op=%h with no beat expected", Op);
      end else if (out_ready) begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("op",       32'(Op),       32'(e[EW-1 -: NCH*LEN]));
        check("merged",   32'(merged),   32'(e[2*NCH + LEN - 1 -: LEN]));
        check("lost",     32'(lost),     32'(e[2*NCH-1 -: NCH]));
        check("sat",      32'(sat),      32'(e[NCH-1:0]));
        check("lost_cnt", 32'(lost_cnt), 32'(exp_cnt));
        if (|e[2*NCH-1 -: NCH] && exp_cnt < 65535) exp_cnt++;
      end else begin
        check("hold_op",     32'(Op),     32'(exp_q[0][EW-1 -: NCH*LEN]));
        check("hold_merged", 32'(merged), 32'(exp_q[0][2*NCH + LEN - 1 -: LEN]));
        check("hold_flags",  32'({lost, sat}), 32'(exp_q[0][2*NCH-1:0]));
      end
    end
  end

  typedef struct {
    logic [0:NCH*LEN-1] ip;
    logic [NCH*SHW-1:0] sh;
    logic               wrap;
    logic [EW-1:0]      exp;
  } vec_t;

  vec_t tv[9];

  initial begin
    logic acc;
    int   k;
    logic saw_stall;

    // {Op ch0, Op ch1, merged, lost[1:0], sat[1:0]}; shift = {ch1, ch0}.
    tv[0] = '{{8'b0000_0010, 8'b0}, {3'd0, 3'd2}, 1'b0,
              {8'b0000_1000, 8'b0, 8'b0000_1000, 2'b00, 2'b00}};
    tv[1] = '{{8'b0000_0010, 8'b0}, {3'd0, 3'b110}, 1'b0,
              {8'b0, 8'b0, 8'b0, 2'b01, 2'b00}};
    tv[2] = '{{8'b0000_0010, 8'b0}, {3'd0, 3'b110}, 1'b1,
              {8'b1000_0000, 8'b0, 8'b1000_0000, 2'b00, 2'b00}};
    tv[3] = '{{8'b0110_0011, 8'b0}, {3'd0, 3'd3}, 1'b0,
              {8'b1000_1100, 8'b0, 8'b1000_1100, 2'b01, 2'b01}};
    tv[4] = '{{8'b0000_0010, 8'b0000_1000}, {3'b111, 3'd1}, 1'b0,
              {8'b0000_0100, 8'b0000_0100, 8'b0000_0100, 2'b00, 2'b00}};
    tv[5] = '{{8'b1111_1111, 8'b1100_0001}, {3'b100, 3'd0}, 1'b1,
              {8'hFF, 8'b0111_0000, 8'hFF, 2'b00, 2'b10}};
    tv[6] = '{{8'b0, 8'b0}, {3'd1, 3'd1}, 1'b0,
              {8'b0, 8'b0, 8'b0, 2'b00, 2'b00}};
    tv[7] = '{{8'b1010_0101, 8'b0101_1010}, {3'd0, 3'd0}, 1'b0,
              {8'b1010_0101, 8'b0101_1010, 8'hFF, 2'b00, 2'b00}};
    tv[8] = '{{8'b1000_0001, 8'b1000_0001}, {3'b111, 3'd1}, 1'b0,
              {8'b0000_0010, 8'b0100_0000, 8'b0100_0010, 2'b11, 2'b00}};

    rst = 1'b1; in_valid = 1'b0; Ip = '0; shift = '0; wrap_en = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_lost_cnt",  32'(lost_cnt),  32'(0));
    check("rst_op",        32'(Op),        32'(0));
    check("rst_flags",     32'({merged, lost, sat}), 32'(0));
    @(negedge clk);

    // Two-cycle latency on the first beat.
    drive_cycle(1'b1, tv[0].ip, tv[0].sh, tv[0].wrap, 1'b1, tv[0].exp, acc);
    in_valid = 1'b0;
    #1;
    check("lat_cycle1", 32'(out_valid), 32'(0));
    @(negedge clk);
    #1;
    check("lat_cycle2", 32'(out_valid), 32'(1));
    @(negedge clk);

    for (int i = 1; i < 9; i++) send(tv[i].ip, tv[i].sh, tv[i].wrap, tv[i].exp);
    drain();
    check("lost_cnt_table", 32'(lost_cnt), 32'(3));

    // Backpressure: out_ready low in cycles 3..5 of a 6-beat burst.
    k = 0;
    saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && (k < 6 || exp_q.size() != 0); cyc++) begin
      logic ordy;
      logic [0:NCH*LEN-1] ip;
      logic [NCH*SHW-1:0] sh;
      ordy = !(cyc >= 3 && cyc <= 5);
      ip   = {8'(k + 1), 8'(8'h81 << k)};
      sh   = 6'(k * 9 + 1);
      if (k < 6) begin
        drive_cycle(1'b1, ip, sh, 1'(k % 2), ordy, model_beat(ip, sh, 1'(k % 2)), acc);
        if (acc) k++;
        else saw_stall = 1'b1;
      end else begin
        idle(1, ordy);
      end
    end
    check("bp_in_ready_drop", 32'(saw_stall), 32'(1));
    check("bp_all_sent",      32'(k),         32'(6));
    drain();

    // Reset with two beats in flight: neither may ever appear.
    send({8'b0000_0010, 8'b0}, {3'd0, 3'b110}, 1'b0, '0);
    send({8'b0011_0000, 8'b1}, {3'd1, 3'd1}, 1'b0, '0);
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_lost_cnt",  32'(lost_cnt),  32'(0));
    check("mid_rst_in_ready",  32'(in_ready),  32'(1));
    @(negedge clk);
    idle(5, 1'b1);

    // Random traffic with random downstream stalls.
    k = 0;
    for (int cyc = 0; cyc < 400 && k < 40; cyc++) begin
      logic v;
      logic ordy;
      logic w;
      logic [0:NCH*LEN-1] ip;
      logic [NCH*SHW-1:0] sh;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      w    = 1'($urandom_range(0, 1));
      ip   = 16'($urandom_range(0, 65535));
      sh   = 6'($urandom_range(0, 63));
      drive_cycle(v, ip, sh, w, ordy, model_beat(ip, sh, w), acc);
      if (acc) k++;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
